// File: rtl/hazard_fwd_unit.sv
// Forwarding and hazard controller for the 5-stage RV32 core (EX-stage operand bypass, load-use / mul-div stalls).
// Latency: forwarding is combinational (0 cycles); stall/hold outputs are asserted combinationally in the detection cycle.
// Backpressure: mem_stall freezes the FSM, counter and captured operands; stall_pc/hold_ex follow state, flush_id_ex is forced low.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   mem_stall                  global pipeline freeze from the D-cache
//   id_rs/id_rs_used           ID-stage source indices and read enables (load-use check)
//   ex_rs/ex_rd/ex_regwrite    EX-stage sources, destination, write enable
//   ex_is_load/ex_is_muldiv    EX instruction class
//   mem_*                      EX/MEM destination, write enable, jump flag, data sources
//   wb_*                       MEM/WB destination, write enable, write-back data
//   stall_pc/flush_id_ex/hold_ex  pipeline control
//   fwd_flag/fwd_dat           per-operand override flag and data
//   hz_state                   FSM state for debug
module hazard_fwd_unit #(
    parameter int XLEN    = 32,
    parameter int AW      = 5,
    parameter int NUM_OPS = 2,
    parameter int LU_CYC  = 1,
    parameter int MD_HOLD = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mem_stall,
    input  logic [NUM_OPS*AW-1:0]   id_rs,
    input  logic [NUM_OPS-1:0]      id_rs_used,
    input  logic [NUM_OPS*AW-1:0]   ex_rs,
    input  logic [AW-1:0]           ex_rd,
    input  logic                    ex_regwrite,
    input  logic                    ex_is_load,
    input  logic                    ex_is_muldiv,
    input  logic [AW-1:0]           mem_rd,
    input  logic                    mem_regwrite,
    input  logic                    mem_jump,
    input  logic [XLEN-1:0]         mem_alu_result,
    input  logic [XLEN-1:0]         mem_pc_step,
    input  logic [AW-1:0]           wb_rd,
    input  logic                    wb_regwrite,
    input  logic [XLEN-1:0]         wb_data,
    output logic                    stall_pc,
    output logic                    flush_id_ex,
    output logic                    hold_ex,
    output logic [NUM_OPS-1:0]      fwd_flag,
    output logic [NUM_OPS*XLEN-1:0] fwd_dat,
    output logic [1:0]              hz_state
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MD_BUSY  = 2'd2
    } hz_state_e;

    // Registered state
    hz_state_e               state_q,    state_d;
    logic [7:0]              cnt_q,      cnt_d;
    logic [NUM_OPS-1:0]      cap_flag_q, cap_flag_d;
    logic [NUM_OPS*XLEN-1:0] cap_dat_q,  cap_dat_d;

    // Combinational intermediates
    logic [NUM_OPS-1:0]      live_flag;
    logic [NUM_OPS*XLEN-1:0] live_dat;
    logic                    lu_hit;
    logic                    stall_pc_c;
    logic                    flush_id_ex_c;
    logic                    hold_ex_c;
    logic                    use_cap;

    // ------------------------------------------------------------------
    // Live forwarding. EX/MEM is the younger producer, so it wins over
    // MEM/WB. x0 is hard-wired zero and must never be forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        live_flag = '0;
        live_dat  = '0;
        for (int i = 0; i < NUM_OPS; i++) begin
            if (mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs[i*AW +: AW])) begin
                live_flag[i]             = 1'b1;
                // Link instructions write PC+4, not the ALU result.
                live_dat[i*XLEN +: XLEN] = mem_jump ? mem_pc_step : mem_alu_result;
            end else if (wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs[i*AW +: AW])) begin
                live_flag[i]             = 1'b1;
                live_dat[i*XLEN +: XLEN] = wb_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load-use: an ID-stage instruction actually reads the register a
    // load in EX is about to produce.
    // ------------------------------------------------------------------
    always_comb begin
        lu_hit = 1'b0;
        if (ex_is_load && ex_regwrite && (ex_rd != '0)) begin
            for (int i = 0; i < NUM_OPS; i++) begin
                if (id_rs_used[i] && (id_rs[i*AW +: AW] == ex_rd)) begin
                    lu_hit = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Hazard FSM next-state and control outputs.
    // The detection cycle itself counts as the first stall/hold cycle,
    // hence the counters are loaded with N-2 and the multi-cycle state
    // is skipped entirely when N==1.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cap_flag_d    = cap_flag_q;
        cap_dat_d     = cap_dat_q;
        stall_pc_c    = 1'b0;
        flush_id_ex_c = 1'b0;
        hold_ex_c     = 1'b0;
        use_cap       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A frozen pipeline must not start a new stall: the
                // instructions in ID/EX are not advancing anyway.
                if (!mem_stall) begin
                    if (ex_is_muldiv) begin
                        hold_ex_c  = 1'b1;
                        stall_pc_c = 1'b1;
                        // Producers retire while EX is held; snapshot the
                        // operands now so the mul/div keeps valid inputs.
                        cap_flag_d = live_flag;
                        cap_dat_d  = live_dat;
                        if (MD_HOLD > 1) begin
                            state_d = ST_MD_BUSY;
                            cnt_d   = 8'(MD_HOLD - 2);
                        end
                    end else if (lu_hit) begin
                        stall_pc_c    = 1'b1;
                        flush_id_ex_c = 1'b1;
                        if (LU_CYC > 1) begin
                            state_d = ST_LU_STALL;
                            cnt_d   = 8'(LU_CYC - 2);
                        end
                    end
                end
            end

            ST_LU_STALL: begin
                stall_pc_c = 1'b1;
                if (!mem_stall) begin
                    flush_id_ex_c = 1'b1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            ST_MD_BUSY: begin
                stall_pc_c = 1'b1;
                hold_ex_c  = 1'b1;
                use_cap    = 1'b1;
                // ex_is_muldiv is deliberately ignored here: the held
                // instruction is the same one, so it must not retrigger.
                if (!mem_stall) begin
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            cap_flag_q <= '0;
            cap_dat_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cap_flag_q <= cap_flag_d;
            cap_dat_q  <= cap_dat_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Forwarding and detection are combinational, so they are
    // gated with rst_n to keep every output quiet while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        stall_pc    = rst_n & stall_pc_c;
        flush_id_ex = rst_n & flush_id_ex_c;
        hold_ex     = rst_n & hold_ex_c;
        hz_state    = rst_n ? state_q : 2'd0;
        if (!rst_n) begin
            fwd_flag = '0;
            fwd_dat  = '0;
        end else if (use_cap) begin
            fwd_flag = cap_flag_q;
            fwd_dat  = cap_dat_q;
        end else begin
            fwd_flag = live_flag;
            fwd_dat  = live_dat;
        end
    end

endmodule
